// File: rtl/piano_key_scanner_if.sv
// ----------------------------------------------------------------------------
// piano_key_scanner_if
// Chord hand-off between the key scanner (master) and the synth LISTEN stage
// (slave). A chord moves on a clock edge where chord_valid and chord_ready
// are both high.
//   chord_valid  master -> slave  a chord is offered
//   chord_ready  slave  -> master consumer takes the offered chord
//   chord_data   master -> slave  offered chord (bit i = key i), held stable
//                                 while chord_valid=1 and chord_ready=0
// ----------------------------------------------------------------------------
interface piano_key_scanner_if #(
  parameter int NKEYS = 8
) ();
  logic             chord_valid;
  logic             chord_ready;
  logic [NKEYS-1:0] chord_data;

  modport master (output chord_valid, output chord_data, input chord_ready);
  modport slave  (input chord_valid, input chord_data, output chord_ready);
endinterface

// File: rtl/piano_key_scanner.sv
// ----------------------------------------------------------------------------
// piano_key_scanner
// Samples NKEYS raw key levels, synchronises each through two flops,
// debounces each key independently and offers every new stable chord to the
// synth core over a valid/ready hand-off. When the consumer stalls, the
// offered chord is held; if further chords arrive meanwhile, the most recent
// one is offered right after the stalled transfer completes (latest wins).
//
// Ports
//   clk          in   single clock, posedge
//   rst_n        in   asynchronous active-low reset
//   keys_raw     in   raw key levels (async to clk), 1 = pressed
//   chord        out  live debounced chord
//   any_key      out  |chord
//   bus          master modport of piano_key_scanner_if
//   overrun      out  sticky "a chord was discarded"   (KEY_SCAN_OVERRUN_EN)
//   overrun_clr  in   clears overrun, wins over set     (KEY_SCAN_OVERRUN_EN)
//
// Configuration
//   KEY_SCAN_OVERRUN_EN  when defined, adds the overrun/overrun_clr ports and
//                        the sticky overrun flag.
// ----------------------------------------------------------------------------
module piano_key_scanner #(
  parameter int NKEYS     = 8,
  parameter int DB_CYCLES = 50000,
  parameter int DB_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NKEYS-1:0] keys_raw,
  output logic [NKEYS-1:0] chord,
  output logic             any_key,
  piano_key_scanner_if.master bus
`ifdef KEY_SCAN_OVERRUN_EN
  ,
  output logic             overrun,
  input  logic             overrun_clr
`endif
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic {IDLE, PEND} state_t;

  logic [NKEYS-1:0] sync_1;
  logic [NKEYS-1:0] ksync;
  logic [DB_W-1:0]  db_cnt [NKEYS];
  logic [NKEYS-1:0] key_upd;
  logic             chord_chg;
  logic             pend_newer;
  state_t           state;

  // Two-flop synchroniser; ksync is the only view of the keys used below.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= '0;
      ksync  <= '0;
    end else begin
      sync_1 <= keys_raw;
      ksync  <= sync_1;
    end
  end

  // A key flips once it has disagreed with the accepted level for DB_CYCLES
  // consecutive samples.
  // NOTE: combinational blocks assign a default first so no latch is inferred.
  always_comb begin
    key_upd = '0;
    for (int i = 0; i < NKEYS; i++) begin
      key_upd[i] = (ksync[i] != chord[i]) && (db_cnt[i] == DB_LAST);
    end
  end

  // NOTE: the per-key counters are a handful of flops, not a RAM, so they are
  // reset explicitly along with the chord they qualify.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chord     <= '0;
      chord_chg <= 1'b0;
      for (int i = 0; i < NKEYS; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        if (ksync[i] == chord[i]) begin
          db_cnt[i] <= '0;
        end else if (key_upd[i]) begin
          chord[i]  <= ksync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
      // Any number of keys settling together is one chord change; the FSM
      // sees it the cycle after chord has taken its new value.
      chord_chg <= |key_upd;
    end
  end

  assign any_key = |chord;

  // Hand-off FSM. chord_data only loads when nothing is pending or the
  // current offer is being accepted on this edge, which keeps it stable
  // under back-pressure. pend_newer remembers that chord moved on meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus.chord_valid <= 1'b0;
      bus.chord_data  <= '0;
      pend_newer      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (chord_chg) begin
            bus.chord_data  <= chord;
            bus.chord_valid <= 1'b1;
            pend_newer      <= 1'b0;
            state           <= PEND;
          end
        end
        PEND: begin
          if (bus.chord_ready) begin
            if (chord_chg || pend_newer) begin
              bus.chord_data <= chord;
              pend_newer     <= 1'b0;
            end else begin
              bus.chord_valid <= 1'b0;
              state           <= IDLE;
            end
          end else if (chord_chg) begin
            pend_newer <= 1'b1;
          end
        end
        default: begin
          state           <= IDLE;
          bus.chord_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef KEY_SCAN_OVERRUN_EN
  // A second unseen change while stalled means an intermediate chord is gone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end else if (state == PEND && !bus.chord_ready && chord_chg && pend_newer) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_piano_key_scanner.sv
// ----------------------------------------------------------------------------
// tb_piano_key_scanner
// Self-checking bench for piano_key_scanner with DB_CYCLES=4. A reference
// model derives the debounced chord from a window over the raw key history:
// a key takes level v once the raw samples seen 2..DB_CYCLES+1 edges ago all
// equal v and differ from its current level. Transfers are captured by a
// monitor and compared with expected chord sequences.
// ----------------------------------------------------------------------------
module tb_piano_key_scanner;

  localparam int NKEYS = 8;
  localparam int DB    = 4;
  localparam int HLEN  = DB + 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NKEYS-1:0] keys_raw;
  logic [NKEYS-1:0] chord;
  logic             any_key;
`ifdef KEY_SCAN_OVERRUN_EN
  logic             overrun;
  logic             overrun_clr;
`endif

  piano_key_scanner_if #(.NKEYS(NKEYS)) bus ();

  piano_key_scanner #(
    .NKEYS(NKEYS),
    .DB_CYCLES(DB),
    .DB_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .keys_raw(keys_raw),
    .chord(chord),
    .any_key(any_key),
    .bus(bus)
`ifdef KEY_SCAN_OVERRUN_EN
    ,
    .overrun(overrun),
    .overrun_clr(overrun_clr)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  logic [NKEYS-1:0] hist [$];
  logic [NKEYS-1:0] m_chord;
  logic [NKEYS-1:0] m_changes [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      for (int k = 0; k < HLEN; k++) hist.push_back('0);
      m_chord = '0;
    end else begin
      logic [NKEYS-1:0] nxt;
      hist.push_back(keys_raw);
      if (hist.size() > HLEN) void'(hist.pop_front());
      nxt = m_chord;
      for (int i = 0; i < NKEYS; i++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int k = 2; k <= DB + 1; k++)
          if (hist[hist.size() - 1 - k][i] == m_chord[i]) all_diff = 1'b0;
        if (all_diff) nxt[i] = ~m_chord[i];
      end
      if (nxt != m_chord) m_changes.push_back(nxt);
      m_chord = nxt;
    end
  end

  // ---------------- monitor ----------------
  logic [NKEYS-1:0] xfers [$];
  logic             p_valid, p_ready;
  logic [NKEYS-1:0] p_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_valid = 1'b0;
      p_ready = 1'b0;
      p_data  = '0;
    end else begin
      checks++;
      if (chord !== m_chord || any_key !== (|m_chord)) begin
        failures++;
        $display("FAIL model_chord t=%0t chord=%h any_key=%b expected chord=%h", $time, chord, any_key, m_chord);
      end
      if (p_valid && !p_ready) begin
        checks++;
        if (bus.chord_valid !== 1'b1 || bus.chord_data !== p_data) begin
          failures++;
          $display("FAIL stall_hold t=%0t valid=%b data=%h expected valid=1 data=%h", $time, bus.chord_valid, bus.chord_data, p_data);
        end
      end
      if (bus.chord_valid && bus.chord_ready) xfers.push_back(bus.chord_data);
      p_valid = bus.chord_valid;
      p_ready = bus.chord_ready;
      p_data  = bus.chord_data;
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_xfers(input int n, input int budget, output bit ok);
    int c;
    c = 0;
    while (xfers.size() < n && c < budget) begin
      step(1);
      c++;
    end
    ok = (xfers.size() >= n);
  endtask

  // Release all keys and let the note-off drain with the consumer ready.
  task automatic settle_idle();
    keys_raw = '0;
    bus.chord_ready = 1'b1;
    step(20);
    xfers.delete();
    m_changes.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if (chord !== '0 || any_key !== 1'b0 || bus.chord_valid !== 1'b0 || bus.chord_data !== '0) begin
      failures++;
      $display("FAIL reset_state chord=%h any=%b valid=%b data=%h expected all 0", chord, any_key, bus.chord_valid, bus.chord_data);
    end
`ifdef KEY_SCAN_OVERRUN_EN
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_overrun overrun=%b expected 0", overrun);
    end
`endif
  endtask

  task automatic test_clean_press();
    bit ok;
    bus.chord_ready = 1'b1;
    keys_raw = 8'h80;
    step(5);
    checks++;
    if (chord !== 8'h00) begin
      failures++;
      $display("FAIL press_early chord=%h expected 00 at cycle 5", chord);
    end
    step(1);
    checks++;
    if (chord !== 8'h80 || bus.chord_valid !== 1'b0) begin
      failures++;
      $display("FAIL press_cycle6 chord=%h valid=%b expected chord=80 valid=0", chord, bus.chord_valid);
    end
    step(1);
    checks++;
    if (bus.chord_valid !== 1'b1 || bus.chord_data !== 8'h80) begin
      failures++;
      $display("FAIL press_cycle7 valid=%b data=%h expected valid=1 data=80", bus.chord_valid, bus.chord_data);
    end
    step(1);
    checks++;
    if (bus.chord_valid !== 1'b0 || xfers.size() != 1) begin
      failures++;
      $display("FAIL press_one_cycle valid=%b xfers=%0d expected valid=0 xfers=1", bus.chord_valid, xfers.size());
    end
    keys_raw = 8'h00;
    wait_xfers(2, 30, ok);
    checks++;
    if (!ok || xfers[1] !== 8'h00) begin
      failures++;
      $display("FAIL release_noteoff xfers=%0d last=%h expected 2 transfers ending 00", xfers.size(), ok ? xfers[1] : 8'hxx);
    end
    settle_idle();
  endtask

  task automatic test_bounce();
    bus.chord_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      keys_raw = 8'h01;
      step(2);
      keys_raw = 8'h00;
      step(2);
    end
    checks++;
    if (chord !== 8'h00 || xfers.size() != 0) begin
      failures++;
      $display("FAIL bounce_ignored chord=%h xfers=%0d expected chord=00 xfers=0", chord, xfers.size());
    end
    keys_raw = 8'h01;
    step(15);
    checks++;
    if (xfers.size() != 1 || xfers[0] !== 8'h01) begin
      failures++;
      $display("FAIL bounce_settle xfers=%0d first=%h expected 1 transfer of 01", xfers.size(), xfers.size() > 0 ? xfers[0] : 8'hxx);
    end
    settle_idle();
  endtask

  task automatic test_backpressure();
    bit ok;
    bus.chord_ready = 1'b0;
    keys_raw = 8'h01;
    step(10);
    checks++;
    if (bus.chord_valid !== 1'b1 || bus.chord_data !== 8'h01) begin
      failures++;
      $display("FAIL bp_first valid=%b data=%h expected valid=1 data=01", bus.chord_valid, bus.chord_data);
    end
    keys_raw = 8'h03;
    step(10);
    checks++;
    if (chord !== 8'h03 || bus.chord_data !== 8'h01) begin
      failures++;
      $display("FAIL bp_hold chord=%h data=%h expected chord=03 data=01", chord, bus.chord_data);
    end
    bus.chord_ready = 1'b1;
    wait_xfers(2, 10, ok);
    step(5);
    checks++;
    if (!ok || xfers.size() != 2 || xfers[0] !== 8'h01 || xfers[1] !== 8'h03) begin
      failures++;
      $display("FAIL bp_sequence xfers=%0d expected exactly 01 then 03", xfers.size());
    end
    checks++;
    if (bus.chord_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_idle valid=%b expected 0", bus.chord_valid);
    end
    settle_idle();
  endtask

  task automatic test_chord();
    bus.chord_ready = 1'b1;
    keys_raw = 8'h81;
    step(15);
    checks++;
    if (xfers.size() != 1 || xfers[0] !== 8'h81 || any_key !== 1'b1) begin
      failures++;
      $display("FAIL chord_same_cycle xfers=%0d first=%h any_key=%b expected one 81 with any_key=1", xfers.size(), xfers.size() > 0 ? xfers[0] : 8'hxx, any_key);
    end
    settle_idle();
  endtask

  task automatic test_overrun();
    bit ok;
    bus.chord_ready = 1'b0;
    keys_raw = 8'h01;
    step(10);
    keys_raw = 8'h03;
    step(10);
    keys_raw = 8'h07;
    step(10);
`ifdef KEY_SCAN_OVERRUN_EN
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set overrun=%b expected 1", overrun);
    end
`endif
    bus.chord_ready = 1'b1;
    wait_xfers(2, 10, ok);
    step(5);
    checks++;
    if (!ok || xfers.size() != 2 || xfers[0] !== 8'h01 || xfers[1] !== 8'h07) begin
      failures++;
      $display("FAIL overrun_latest xfers=%0d expected exactly 01 then 07", xfers.size());
    end
`ifdef KEY_SCAN_OVERRUN_EN
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky overrun=%b expected 1", overrun);
    end
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear overrun=%b expected 0", overrun);
    end
`endif
    settle_idle();
  endtask

  task automatic test_random();
    int pos;
    bit in_order;
    for (int it = 0; it < 500; it++) begin
      if ($urandom_range(0, 2) == 0) keys_raw = 8'($urandom);
      else keys_raw = keys_raw ^ (8'h1 << $urandom_range(0, 7));
      bus.chord_ready = ($urandom_range(0, 2) != 0);
      step($urandom_range(1, 8));
    end
    bus.chord_ready = 1'b1;
    step(20);
    checks++;
    if (xfers.size() == 0 || xfers[xfers.size() - 1] !== m_chord) begin
      failures++;
      $display("FAIL random_final xfers=%0d last=%h expected last=%h", xfers.size(), xfers.size() > 0 ? xfers[xfers.size() - 1] : 8'hxx, m_chord);
    end
    // Every transfer must be a model chord, in the order the chords occurred.
    pos = 0;
    in_order = 1'b1;
    foreach (xfers[k]) begin
      while (pos < m_changes.size() && m_changes[pos] !== xfers[k]) pos++;
      if (pos >= m_changes.size()) in_order = 1'b0;
      else pos++;
    end
    checks++;
    if (!in_order) begin
      failures++;
      $display("FAIL random_order transfers=%0d model_changes=%0d expected ordered subsequence", xfers.size(), m_changes.size());
    end
    settle_idle();
  endtask

  task automatic test_reset_mid();
    bus.chord_ready = 1'b0;
    keys_raw = 8'h10;
    step(10);
    checks++;
    if (bus.chord_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_valid valid=%b expected 1", bus.chord_valid);
    end
    keys_raw = 8'h00;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.chord_valid !== 1'b0 || chord !== 8'h00 || any_key !== 1'b0) begin
      failures++;
      $display("FAIL rst_async valid=%b chord=%h any=%b expected all 0", bus.chord_valid, chord, any_key);
    end
    step(2);
    rst_n = 1'b1;
    xfers.delete();
    bus.chord_ready = 1'b1;
    step(15);
    checks++;
    if (xfers.size() != 0 || bus.chord_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_replay xfers=%0d valid=%b expected 0 and 0", xfers.size(), bus.chord_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    keys_raw = '0;
    bus.chord_ready = 1'b0;
`ifdef KEY_SCAN_OVERRUN_EN
    overrun_clr = 1'b0;
`endif
    step(3);
    rst_n = 1'b1;
    step(1);
    test_reset();
    test_clean_press();
    test_bounce();
    test_backpressure();
    test_chord();
    test_overrun();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
